// File: rtl/lutram_fifo_ctrl_pkg.sv
// Shared types and helpers for the LUT-RAM backed FWFT FIFO controller.
// Pointers are one bit wider than the RAM address; the extra MSB is a wrap
// bit that distinguishes full from empty when the address bits match.
package lutram_fifo_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned ADDR_BITS  = 5;
  localparam int unsigned COUNT_BITS = 6;

  typedef logic [COUNT_BITS-1:0] ptr_t;
  typedef logic [ADDR_BITS-1:0]  addr_t;

  // Occupancy view derived purely from the two pointers
  typedef struct packed {
    logic [COUNT_BITS-1:0] count;
    logic                  full;
    logic                  empty;
  } fifo_status_t;

  // Strip the wrap bit to get the RAM address
  function automatic addr_t ptr_addr(input ptr_t p);
    return p[ADDR_BITS-1:0];
  endfunction

  // Occupancy, full and empty from write/read pointers
  function automatic fifo_status_t fifo_status(input ptr_t wr, input ptr_t rd);
    fifo_status_t s;
    s.count = COUNT_BITS'(wr - rd);
    s.full  = (ptr_addr(wr) == ptr_addr(rd)) && (wr[ADDR_BITS] != rd[ADDR_BITS]);
    s.empty = (wr == rd);
    return s;
  endfunction

endpackage

// File: rtl/lutram_fifo_ptr.sv
// Wrap-bit FIFO pointer: increments on enable, synchronously cleared.
// Clear has priority over increment so a discarded push/pop never moves it.
module lutram_fifo_ptr
  import lutram_fifo_ctrl_pkg::*;
(
  input  logic clock,
  input  logic i_clear,
  input  logic i_inc,
  output ptr_t o_ptr
);

  ptr_t r_ptr;

  // Pointer register; the 5-bit address rolls 31 -> 0 and toggles the MSB
  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= COUNT_BITS'(r_ptr + COUNT_BITS'(1));
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for a bank of WIDTH 32x1 LUT-RAM
// bit-slices (synchronous write, asynchronous read). The bank itself lives
// in the parent; this block produces its write enable and addresses and
// routes data through.
// Optional build macro LUTRAM_FIFO_ERROR_FLAGS_EN adds sticky overflow and
// underflow outputs, cleared only by reset or flush.
module lutram_fifo_ctrl
  import lutram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  pushValid,
  output logic                  pushReady,
  input  logic [WIDTH-1:0]      pushData,
  output logic                  popValid,
  input  logic                  popReady,
  output logic [WIDTH-1:0]      popData,
  output logic [COUNT_BITS-1:0] count,
  output logic                  full,
  output logic                  empty,
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  ramWe,
  output logic [DEPTH_LOG2-1:0] ramWriteAddress,
  output logic [DEPTH_LOG2-1:0] ramReadAddress,
  output logic [WIDTH-1:0]      ramDataIn,
  input  logic [WIDTH-1:0]      ramDataOut
);

  ptr_t         w_wr_ptr;
  ptr_t         w_rd_ptr;
  fifo_status_t w_status;
  logic         w_clear;
  logic         w_push_acc;
  logic         w_pop_acc;

  // Handshake decode; ready/valid come only from registered pointers, so
  // there is no path from popReady to pushReady or pushValid to popValid
  always_comb begin
    w_clear    = reset | flush;
    w_status   = fifo_status(w_wr_ptr, w_rd_ptr);
    w_push_acc = pushValid & ~w_status.full  & ~w_clear;
    w_pop_acc  = popReady  & ~w_status.empty & ~w_clear;
  end

  lutram_fifo_ptr u_wr_ptr (
    .clock   (clock),
    .i_clear (w_clear),
    .i_inc   (w_push_acc),
    .o_ptr   (w_wr_ptr)
  );

  lutram_fifo_ptr u_rd_ptr (
    .clock   (clock),
    .i_clear (w_clear),
    .i_inc   (w_pop_acc),
    .o_ptr   (w_rd_ptr)
  );

  // Status and handshake outputs
  assign count     = w_status.count;
  assign full      = w_status.full;
  assign empty     = w_status.empty;
  assign pushReady = ~w_status.full;
  assign popValid  = ~w_status.empty;

  // LUT-RAM bank interface: write at the tail, read asynchronously at the head
  assign ramWe           = w_push_acc;
  assign ramWriteAddress = DEPTH_LOG2'(ptr_addr(w_wr_ptr));
  assign ramReadAddress  = DEPTH_LOG2'(ptr_addr(w_rd_ptr));
  assign ramDataIn       = pushData;
  assign popData         = ramDataOut;

`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; illegal attempts never move the pointers
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (pushValid && w_status.full) begin
        r_overflow <= 1'b1;
      end
      if (popReady && w_status.empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Self-checking bench for lutram_fifo_ctrl: a simple LUT-RAM bank model,
// a queue-based reference of FIFO contents, and a negedge monitor that
// compares status every cycle and pops the scoreboard on each pop handshake.
module tb_lutram_fifo_ctrl;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          pushValid = 1'b0;
  logic          pushReady;
  logic [W-1:0]  pushData = '0;
  logic          popValid;
  logic          popReady = 1'b0;
  logic [W-1:0]  popData;
  logic [5:0]    count;
  logic          full;
  logic          empty;
  logic          ramWe;
  logic [4:0]    ramWriteAddress;
  logic [4:0]    ramReadAddress;
  logic [W-1:0]  ramDataIn;
  logic [W-1:0]  ramDataOut;
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  lutram_fifo_ctrl #(.WIDTH(W), .DEPTH_LOG2(5)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .pushValid       (pushValid),
    .pushReady       (pushReady),
    .pushData        (pushData),
    .popValid        (popValid),
    .popReady        (popReady),
    .popData         (popData),
    .count           (count),
    .full            (full),
    .empty           (empty),
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
    .overflow        (overflow),
    .underflow       (underflow),
`endif
    .ramWe           (ramWe),
    .ramWriteAddress (ramWriteAddress),
    .ramReadAddress  (ramReadAddress),
    .ramDataIn       (ramDataIn),
    .ramDataOut      (ramDataOut)
  );

  always #5 clock = ~clock;

  // LUT-RAM bank: synchronous write, asynchronous read
  logic [W-1:0] mem [32];
  always @(posedge clock) if (ramWe) mem[ramWriteAddress] <= ramDataIn;
  assign ramDataOut = mem[ramReadAddress];

  // Reference model state
  logic [W-1:0] sb [$];
  int  m_count = 0;
  int  m_wr = 0;
  int  m_rd = 0;
  bit  m_ovf = 0;
  bit  m_udf = 0;
  bit  done = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model advances by the spec rules at the edge
  task automatic step(input bit pv, input bit pr, input bit fl, input bit rs, input logic [W-1:0] d);
    bit clr, pacc, racc;
    pushValid = pv; popReady = pr; flush = fl; reset = rs; pushData = d;
    clr  = rs || fl;
    pacc = pv && (m_count < 32) && !clr;
    racc = pr && (m_count > 0) && !clr;
    @(posedge clock);
    if (clr) begin
      sb.delete();
      m_count = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (pv && m_count == 32) m_ovf = 1;
      if (pr && m_count == 0)  m_udf = 1;
      if (pacc) begin sb.push_back(d); m_wr = (m_wr + 1) % 64; end
      if (racc) m_rd = (m_rd + 1) % 64;
      m_count = m_count + int'(pacc) - int'(racc);
    end
    #1;
  endtask

  // Monitor: status every cycle, data on each pop handshake
  always @(negedge clock) begin
    if (!done) begin
      check("count", 64'(count), 64'(m_count));
      check("full", 64'(full), 64'(m_count == 32));
      check("empty", 64'(empty), 64'(m_count == 0));
      check("pushReady", 64'(pushReady), 64'(m_count != 32));
      check("popValid", 64'(popValid), 64'(m_count != 0));
      check("ramWe", 64'(ramWe), 64'(pushValid && m_count < 32 && !reset && !flush));
      check("ramWriteAddress", 64'(ramWriteAddress), 64'(m_wr % 32));
      check("ramReadAddress", 64'(ramReadAddress), 64'(m_rd % 32));
      check("ramDataIn", 64'(ramDataIn), 64'(pushData));
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_udf));
`endif
      if (popValid && popReady && !reset && !flush) begin
        if (sb.size() == 0) begin
          check("pop_with_empty_scoreboard", 64'(1), 64'(0));
        end else begin
          check("popData", 64'(popData), 64'(sb[0]));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset then idle
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_popValid", 64'(popValid), 64'(0));
    check("rst_ramWe", 64'(ramWe), 64'(0));

    // Single word into empty FIFO: written at address 0, visible next cycle
    pushValid = 1'b1; pushData = 32'hA5A5_0001; #1;
    check("first_ramWe", 64'(ramWe), 64'(1));
    check("first_waddr", 64'(ramWriteAddress), 64'(0));
    step(1, 0, 0, 0, 32'hA5A5_0001);
    check("first_popValid", 64'(popValid), 64'(1));
    check("first_popData", 64'(popData), 64'hA5A5_0001);
    check("first_count", 64'(count), 64'(1));
    step(0, 1, 0, 0, '0);

    // Fill with 0..31, then a rejected 33rd push
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, W'(i));
    step(0, 0, 0, 0, '0);
    check("fill_count", 64'(count), 64'(32));
    check("fill_full", 64'(full), 64'(1));
    check("fill_pushReady", 64'(pushReady), 64'(0));
    step(1, 0, 0, 0, 32'hDEAD_BEEF);
    check("ovf_count", 64'(count), 64'(32));
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
    check("ovf_flag", 64'(overflow), 64'(1));
`endif

    // Push and pop together at full: only the pop goes through
    step(1, 1, 0, 0, 32'hBAD0_0000);
    check("full_both_count", 64'(count), 64'(31));

    // 40 pushes with interleaved pops across the address wrap, then drain
    for (int i = 0; i < 40; i++) step(1, (i % 2) == 1, 0, 0, W'(32'h100 + i));
    for (int i = 0; i < 64 && m_count > 0; i++) step(0, 1, 0, 0, '0);
    check("drain_empty", 64'(empty), 64'(1));

    // Steady stream: one word per cycle, occupancy held at one
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 0, 0, W'(32'h2000 + i));
      if (i > 0) check("stream_count", 64'(count), 64'(1));
    end
    step(0, 1, 0, 0, '0);

    // Flush with 17 words queued, then an underflowing pop attempt
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, W'(32'h3000 + i));
    check("pre_flush_count", 64'(count), 64'(17));
    step(0, 0, 1, 0, '0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_empty", 64'(empty), 64'(1));
    step(0, 1, 0, 0, '0);
    check("post_flush_popValid", 64'(popValid), 64'(0));
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
    check("udf_flag", 64'(underflow), 64'(1));
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 150) % 4;
      step($urandom_range(0, 3) >= bias, $urandom_range(0, 3) < bias + 1,
           $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0, W'($urandom));
    end

    // Bounded drain
    for (int i = 0; i < 64 && m_count > 0; i++) step(0, 1, 0, 0, '0);
    check("final_empty", 64'(empty), 64'(1));
    check("final_scoreboard", 64'(sb.size()), 64'(0));

    done = 1;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
